test_pattern_scheduler: RTL and testbench
=========================================

# test_pattern_scheduler

Selects which test pattern drives the DVI and composite pipelines. Pattern changes come from a front-panel button, from an automatic frame-count timer, or from a host load. The block sits beside the 720p timing generator on the pixel clock domain. Its patternSelect output drives the pattern mux ahead of the DVI encoder and PAL generator. Every pattern change is deferred to a frame boundary (vSync leading edge), so no frame is ever torn.

## Interface
Parameters:
- NUM_PATTERNS, 4, number of selectable patterns; legal range 2..8.
- FRAMES_PER_PATTERN, 300, frames shown per pattern in auto-cycle mode; legal range 1..1023.
- DEBOUNCE_BITS, 16, width of the debounce counter; the button must be stable for 2^DEBOUNCE_BITS cycles.
- SYNC_ACTIVE_LOW, 0, polarity of vSync; 1 means the active (leading) edge is falling.

Ports:
- clock  in  1  pixel clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- vSync  in  1  vertical sync from the timing generator.
- nextButton  in  1  raw, asynchronous, active-high push button.
- autoCycle  in  1  level input; 1 enables timed advance.
- loadValid  in  1  single-cycle host load strobe.
- loadPattern  in  3  pattern index captured when loadValid=1.
- patternSelect  out  3  current pattern index.
- patternChange  out  1  one-cycle pulse, asserted with every new patternSelect value.
- frameStrobe  out  1  one-cycle pulse per frame start.
- pending  out  1  a change is queued for the next frame start.

## Operation
- Button path: the button passes through a 2-flop synchronizer and then a debouncer.
  - The debouncer keeps a debounced level `stable` and counter `db`.
  - When the synchronized level equals `stable`, db is cleared to 0.
  - Otherwise db increments. When db reaches all-ones while still differing, `stable` takes the new value and db is cleared to 0.
  - A press event is a 0->1 transition of `stable`. Releases generate no event.
- Frame start: fs = vSync is active this cycle and was inactive the previous cycle (polarity set by SYNC_ACTIVE_LOW).
- Request queue:
  - A press event sets the advance request (advReq).
  - loadValid with loadPattern < NUM_PATTERNS sets the load request (ldReq) and captures the index into ldIdx. A later load overwrites ldIdx.
  - loadValid with loadPattern >= NUM_PATTERNS is dropped with no state change.
  - pending = advReq | ldReq.
- On fs, requests are applied with the following priority:
  1. ldReq set: patternSelect <= ldIdx.
  2. Otherwise, advReq set, or autoCycle=1 and frameCnt == FRAMES_PER_PATTERN-1: patternSelect advances by 1, wrapping NUM_PATTERNS-1 -> 0.
  3. Otherwise: no change.
- On any application: advReq, ldReq and frameCnt are cleared, and patternChange pulses. A load equal to the current index still pulses patternChange.
- frameCnt (10 bits):
  - Increments on fs while autoCycle=1 and no change is applied.
  - Held at 0 while autoCycle=0.
- Coalescing: any number of press events between two frame starts produce exactly one advance.
- Simultaneous events: a press or load arriving in the same cycle as fs is not applied at that fs. The request is retained and applied at the next fs.

## Timing
- Reset (async assert) sets: patternSelect=0, patternChange=0, frameStrobe=0, pending=0, stable=0, db=0, frameCnt=0, both synchronizer flops=0, previous-vSync register = inactive level.
- Reset release: the first fs can occur no earlier than the second rising edge after release.
- Reset asserted mid-operation discards all queued requests immediately.
- fs is combinational in cycle N. In cycle N+1, frameStrobe=1 and the updated patternSelect/patternChange are visible. Latency from vSync edge sample to output is 1 cycle.
- Button latency: 2 synchronizer cycles plus 2^DEBOUNCE_BITS stable cycles, then pending=1 on the following edge.
- Load latency: pending=1 in the cycle after loadValid.
- patternChange and frameStrobe are each high for exactly one cycle per event.
- vSync held at its active level for many cycles produces a single fs.

## Test plan
Simulation parameters: DEBOUNCE_BITS=4, NUM_PATTERNS=4, FRAMES_PER_PATTERN=3.
- Reset checks: reset=0 mid-run with patternSelect=2 and pending=1 -> patternSelect=0 and pending=0 asynchronously. Pulse vSync -> no patternChange.
- Debounce: toggle nextButton every 8 cycles for 100 cycles -> pending stays 0. Hold it high for 20 cycles -> pending=1. At the next vSync edge, patternSelect goes 0->1 and patternChange pulses once.
- Coalescing and wrap: three presses within one frame -> a single advance. Repeat from patternSelect=3 -> wraps to 0.
- Auto-cycle: autoCycle=1, 9 frames -> patternSelect sequence 0,0,0,1,1,1,2,2,2,3 with patternChange on frames 3, 6 and 9. Set autoCycle=0 -> frameCnt=0 and no further changes.
- Load priority and range:
  - loadPattern=2 plus a press in the same frame -> next fs gives patternSelect=2 (load wins). advReq is cleared, so no advance follows.
  - loadPattern=5 -> ignored, pending=0.
- Simultaneous request and frame start: assert loadValid=1 with loadPattern=3 in the same cycle as the vSync edge -> no change at that fs, pending=1. The next fs gives patternSelect=3.

Source files
------------

// File: rtl/test_pattern_scheduler.sv
// Test pattern scheduler: picks the active test pattern index and
// defers every change to the next vSync leading edge.
module test_pattern_scheduler #(
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 300,
  parameter int DEBOUNCE_BITS      = 16,
  parameter bit SYNC_ACTIVE_LOW    = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vSync,
  input  logic       nextButton,
  input  logic       autoCycle,
  input  logic       loadValid,
  input  logic [2:0] loadPattern,
  output logic [2:0] patternSelect,
  output logic       patternChange,
  output logic       frameStrobe,
  output logic       pending
);

  localparam logic [2:0] SEL_LAST = 3'(NUM_PATTERNS - 1);
  localparam logic [3:0] SEL_NUM  = 4'(NUM_PATTERNS);
  localparam logic [9:0] CNT_LAST = 10'(FRAMES_PER_PATTERN - 1);
  localparam logic [DEBOUNCE_BITS-1:0] DB_ONE = DEBOUNCE_BITS'(1);

  logic                     btn_s1;
  logic                     btn_s2;
  logic                     stable;
  logic [DEBOUNCE_BITS-1:0] db;
  logic                     press;

  logic                     vs_act;
  logic                     vs_prev;
  logic                     fs;

  logic                     adv_req;
  logic                     ld_req;
  logic [2:0]               ld_idx;
  logic [9:0]               frame_cnt;

  logic                     load_ok;
  logic                     auto_due;
  logic                     use_ld;
  logic                     use_adv;
  logic                     keep;
  logic                     apply;
  logic [2:0]               sel_inc;
  logic [2:0]               sel_next;

  // Press fires on the same edge that flips the debounced level high.
  assign press    = btn_s2 & ~stable & (&db);

  assign vs_act   = vSync ^ SYNC_ACTIVE_LOW;
  assign fs       = vs_act & ~vs_prev;

  assign load_ok  = loadValid & ({1'b0, loadPattern} < SEL_NUM);
  assign auto_due = autoCycle & (frame_cnt == CNT_LAST);

  assign use_ld   = ld_req;
  assign use_adv  = ~ld_req & (adv_req | auto_due);
  assign keep     = ~use_ld & ~use_adv;
  assign apply    = fs & ~keep;

  assign sel_inc  = (patternSelect == SEL_LAST) ? 3'd0
                                                : patternSelect + 3'd1;

  assign pending  = adv_req | ld_req;

  always_comb begin
    sel_next = patternSelect;
    unique case (1'b1)
      use_ld:  sel_next = ld_idx;
      use_adv: sel_next = sel_inc;
      keep:    sel_next = patternSelect;
      default: sel_next = patternSelect;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= nextButton;
      btn_s2 <= btn_s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      db     <= '0;
    end else if (btn_s2 == stable) begin
      db     <= '0;
    end else if (&db) begin
      stable <= btn_s2;
      db     <= '0;
    end else begin
      db     <= db + DB_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vs_prev     <= 1'b0;
      frameStrobe <= 1'b0;
    end else begin
      vs_prev     <= vs_act;
      frameStrobe <= fs;
    end
  end

  // Requests arriving during an applying fs survive into the next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      adv_req <= 1'b0;
      ld_req  <= 1'b0;
      ld_idx  <= 3'd0;
    end else begin
      adv_req <= (adv_req & ~apply) | press;
      ld_req  <= (ld_req & ~apply) | load_ok;
      if (load_ok) begin
        ld_idx <= loadPattern;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      patternSelect <= 3'd0;
      patternChange <= 1'b0;
    end else begin
      patternChange <= apply;
      if (apply) begin
        patternSelect <= sel_next;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt <= 10'd0;
    end else if (!autoCycle || apply) begin
      frame_cnt <= 10'd0;
    end else if (fs) begin
      frame_cnt <= frame_cnt + 10'd1;
    end
  end

endmodule

// File: tb/tb_test_pattern_scheduler.sv
// Directed bench for test_pattern_scheduler with short debounce and
// three frames per pattern.
module tb_test_pattern_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       vSync = 1'b0;
  logic       nextButton = 1'b0;
  logic       autoCycle = 1'b0;
  logic       loadValid = 1'b0;
  logic [2:0] loadPattern = 3'd0;
  logic [2:0] patternSelect;
  logic       patternChange;
  logic       frameStrobe;
  logic       pending;

  int compared = 0;
  int mismatched = 0;
  logic chg_fs;
  int   chg_extra;
  int   strobes;
  int   seen_pend;

  test_pattern_scheduler #(
    .NUM_PATTERNS(4),
    .FRAMES_PER_PATTERN(3),
    .DEBOUNCE_BITS(4),
    .SYNC_ACTIVE_LOW(1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .vSync(vSync),
    .nextButton(nextButton),
    .autoCycle(autoCycle),
    .loadValid(loadValid),
    .loadPattern(loadPattern),
    .patternSelect(patternSelect),
    .patternChange(patternChange),
    .frameStrobe(frameStrobe),
    .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame(input int hold);
    vSync = 1'b1;
    step();
    chg_fs    = patternChange;
    strobes   = int'(frameStrobe);
    chg_extra = 0;
    for (int i = 1; i < hold; i++) begin
      step();
      strobes   += int'(frameStrobe);
      chg_extra += int'(patternChange);
    end
    vSync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      strobes   += int'(frameStrobe);
      chg_extra += int'(patternChange);
    end
  endtask

  task automatic press();
    nextButton = 1'b1;
    repeat (22) step();
    nextButton = 1'b0;
    repeat (22) step();
  endtask

  task automatic load(input logic [2:0] idx);
    loadValid   = 1'b1;
    loadPattern = idx;
    step();
    loadValid   = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_sel", 32'(patternSelect), 0);
    chk("rst_chg", 32'(patternChange), 0);
    chk("rst_fstb", 32'(frameStrobe), 0);
    chk("rst_pend", 32'(pending), 0);
    reset = 1'b1;
    repeat (2) step();

    // bouncing button never settles
    seen_pend = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 8 == 0) nextButton = ~nextButton;
      step();
      seen_pend += int'(pending);
    end
    nextButton = 1'b0;
    repeat (10) begin
      step();
      seen_pend += int'(pending);
    end
    chk("bounce_pend", 32'(seen_pend), 0);
    nextButton = 1'b1;
    repeat (20) step();
    chk("held_pend", 32'(pending), 1);
    nextButton = 1'b0;
    repeat (22) step();
    chk("release_pend", 32'(pending), 1);
    frame(1);
    chk("press_chg", 32'(chg_fs), 1);
    chk("press_sel", 32'(patternSelect), 1);
    chk("press_chg_once", 32'(chg_extra), 0);
    chk("press_pend_clr", 32'(pending), 0);

    // coalescing and wrap
    press(); press(); press();
    frame(1);
    chk("coal_sel", 32'(patternSelect), 2);
    chk("coal_chg", 32'(chg_fs), 1);
    frame(1);
    chk("coal_single_chg", 32'(chg_fs), 0);
    chk("coal_single_sel", 32'(patternSelect), 2);
    press();
    frame(1);
    chk("to3_sel", 32'(patternSelect), 3);
    press(); press(); press();
    frame(1);
    chk("wrap_sel", 32'(patternSelect), 0);
    chk("wrap_chg", 32'(chg_fs), 1);

    // long vSync gives one frame start
    frame(12);
    chk("long_vs_strobes", 32'(strobes), 1);
    chk("long_vs_chg", 32'(chg_fs), 0);

    // auto-cycle
    autoCycle = 1'b1;
    for (int f = 1; f <= 9; f++) begin
      frame(1);
      chk($sformatf("auto_sel_f%0d", f), 32'(patternSelect), f / 3);
      chk($sformatf("auto_chg_f%0d", f), 32'(chg_fs),
          (f % 3 == 0) ? 1 : 0);
    end
    frame(1);
    frame(1);
    chk("auto_pre_sel", 32'(patternSelect), 3);
    autoCycle = 1'b0;
    frame(1);
    chk("auto_off_chg", 32'(chg_fs), 0);
    autoCycle = 1'b1;
    frame(1);
    chk("auto_re1_chg", 32'(chg_fs), 0);
    frame(1);
    chk("auto_re2_chg", 32'(chg_fs), 0);
    frame(1);
    chk("auto_re3_chg", 32'(chg_fs), 1);
    chk("auto_re3_sel", 32'(patternSelect), 0);
    autoCycle = 1'b0;

    // load beats press; press is consumed too
    load(3'd2);
    chk("load_pend", 32'(pending), 1);
    press();
    frame(1);
    chk("ldpri_sel", 32'(patternSelect), 2);
    chk("ldpri_chg", 32'(chg_fs), 1);
    chk("ldpri_pend", 32'(pending), 0);
    frame(1);
    chk("ldpri_noadv_chg", 32'(chg_fs), 0);
    chk("ldpri_noadv_sel", 32'(patternSelect), 2);

    // out-of-range loads
    load(3'd5);
    chk("bad5_pend", 32'(pending), 0);
    load(3'd4);
    chk("bad4_pend", 32'(pending), 0);
    frame(1);
    chk("bad_chg", 32'(chg_fs), 0);
    chk("bad_sel", 32'(patternSelect), 2);

    // load coincident with frame start
    vSync       = 1'b1;
    loadValid   = 1'b1;
    loadPattern = 3'd3;
    step();
    chk("simul_fstb", 32'(frameStrobe), 1);
    chk("simul_chg", 32'(patternChange), 0);
    chk("simul_sel", 32'(patternSelect), 2);
    chk("simul_pend", 32'(pending), 1);
    vSync     = 1'b0;
    loadValid = 1'b0;
    repeat (3) step();
    frame(1);
    chk("simul_next_sel", 32'(patternSelect), 3);
    chk("simul_next_chg", 32'(chg_fs), 1);

    // reload of current index still pulses
    load(3'd3);
    frame(1);
    chk("same_chg", 32'(chg_fs), 1);
    chk("same_sel", 32'(patternSelect), 3);

    // async reset mid-run
    load(3'd2);
    frame(1);
    chk("pre_rst_sel", 32'(patternSelect), 2);
    load(3'd1);
    chk("pre_rst_pend", 32'(pending), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_sel", 32'(patternSelect), 0);
    chk("async_rst_pend", 32'(pending), 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    frame(1);
    chk("post_rst_chg", 32'(chg_fs), 0);
    chk("post_rst_sel", 32'(patternSelect), 0);
    chk("post_rst_fstb", 32'(strobes), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
